// File: rtl/game_pkg.sv
// game_pkg: game sequencer state encoding and default sizing shared with alien/missile controllers
package game_pkg;
  typedef enum logic [2:0] {ATTRACT, PLAY, HIT, WON, LOST} game_state_t;
  localparam int NUM_ALIENS_D       = 16;
  localparam int START_LIVES_D      = 3;
  localparam int HIT_PAUSE_FRAMES_D = 60;
  localparam int END_HOLD_FRAMES_D  = 180;
endpackage

// File: rtl/game_state_controller_edge_pulse.sv
// edge_pulse: 2-flop synchronizer plus rising-edge detect giving a 1-Clk pulse
module edge_pulse (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic pulse
);
  logic [1:0] sync;
  logic       prev;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync <= 2'b00;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], d};
      prev <= sync[1];
    end
  end
  assign pulse = sync[1] & ~prev;
endmodule

// File: rtl/game_state_controller.sv
// game_state_controller: attract/play/hit/won/lost sequencer with score, lives and freeze control
// Optional player blink during HIT enabled by defining GAME_PLAYER_BLINK_EN.
import game_pkg::*;
module game_state_controller #(
  parameter int NUM_ALIENS       = NUM_ALIENS_D,
  parameter int START_LIVES      = START_LIVES_D,
  parameter int HIT_PAUSE_FRAMES = HIT_PAUSE_FRAMES_D,
  parameter int END_HOLD_FRAMES  = END_HOLD_FRAMES_D
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       alien_hit,
  input  logic       player_hit,
  input  logic       aliens_landed,
  output logic       game_active,
  output logic       freeze,
  output logic       end_game_won,
  output logic       end_game_lost,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       player_blink
);
  localparam int AW = $clog2(NUM_ALIENS + 1);
  game_state_t state, n_state;
  logic [AW-1:0] aliens_left, n_aliens;
  logic [7:0] fcnt, n_fcnt, n_score;
  logic [1:0] n_lives;
  logic frame_tick, start_press, win;
  edge_pulse u_frame (.Clk(Clk), .Reset(Reset), .d(frame_clk), .pulse(frame_tick));
  edge_pulse u_start (.Clk(Clk), .Reset(Reset), .d(start_key), .pulse(start_press));
  assign win = alien_hit && aliens_left == AW'(1);
  always_comb begin
    n_state  = state;
    n_score  = score;
    n_lives  = lives;
    n_aliens = aliens_left;
    n_fcnt   = fcnt;
    case (state)
      ATTRACT: if (start_press) begin
        n_state  = PLAY;
        n_score  = 8'd0;
        n_lives  = 2'(START_LIVES);
        n_aliens = AW'(NUM_ALIENS);
        n_fcnt   = 8'd0;
      end
      PLAY: begin
        if (alien_hit) begin
          n_aliens = aliens_left - AW'(1);
          n_score  = score == 8'hff ? score : score + 8'd1;
        end
        // a wave-clearing hit beats any simultaneous loss
        if (win) begin
          n_state = WON;
          n_fcnt  = 8'd0;
        end else if (aliens_landed) begin
          n_state = LOST;
          n_lives = 2'd0;
          n_fcnt  = 8'd0;
        end else if (player_hit) begin
          n_lives = lives - 2'd1;
          n_state = lives == 2'd1 ? LOST : HIT;
          n_fcnt  = 8'd0;
        end
      end
      HIT: if (frame_tick) begin
        n_state = fcnt == 8'(HIT_PAUSE_FRAMES - 1) ? PLAY : HIT;
        n_fcnt  = fcnt == 8'(HIT_PAUSE_FRAMES - 1) ? 8'd0 : fcnt + 8'd1;
      end
      default: begin
        n_fcnt  = (frame_tick && fcnt < 8'(END_HOLD_FRAMES)) ? fcnt + 8'd1 : fcnt;
        n_state = (start_press && fcnt >= 8'(END_HOLD_FRAMES)) ? ATTRACT : state;
      end
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= ATTRACT;
      score         <= 8'd0;
      lives         <= 2'(START_LIVES);
      aliens_left   <= AW'(NUM_ALIENS);
      fcnt          <= 8'd0;
      game_active   <= 1'b0;
      freeze        <= 1'b1;
      end_game_won  <= 1'b0;
      end_game_lost <= 1'b0;
    end else begin
      state         <= n_state;
      score         <= n_score;
      lives         <= n_lives;
      aliens_left   <= n_aliens;
      fcnt          <= n_fcnt;
      game_active   <= n_state == PLAY;
      freeze        <= n_state != PLAY;
      end_game_won  <= n_state == WON;
      end_game_lost <= n_state == LOST;
    end
  end
`ifdef GAME_PLAYER_BLINK_EN
  always_ff @(posedge Clk) begin
    if (Reset) player_blink <= 1'b0;
    else player_blink <= n_state != HIT ? 1'b0 :
                         state != HIT ? 1'b1 :
                         (frame_tick && fcnt[2:0] == 3'd7) ? ~player_blink : player_blink;
  end
`else
  assign player_blink = 1'b0;
`endif
endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller: directed self-checking bench for game_state_controller
module tb_game_state_controller;
  logic Clk = 0, Reset = 0, frame_clk = 0, start_key = 0;
  logic alien_hit = 0, player_hit = 0, aliens_landed = 0;
  logic game_active, freeze, end_game_won, end_game_lost, player_blink;
  logic [7:0] score;
  logic [1:0] lives;
  int checks = 0, failures = 0;

  game_state_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start_key(start_key),
    .alien_hit(alien_hit), .player_hit(player_hit), .aliens_landed(aliens_landed),
    .game_active(game_active), .freeze(freeze), .end_game_won(end_game_won),
    .end_game_lost(end_game_lost), .score(score), .lives(lives), .player_blink(player_blink)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1; step(4);
      frame_clk = 0; step(4);
    end
  endtask

  task automatic press;
    start_key = 1; step(3);
    start_key = 0; step(1);
  endtask

  task automatic do_reset;
    Reset = 1; step(2);
    Reset = 0; step(1);
  endtask

  task automatic pulse_alien(input logic ph);
    alien_hit = 1; player_hit = ph; step(1);
    alien_hit = 0; player_hit = 0;
  endtask

  task automatic pulse_player;
    player_hit = 1; step(1);
    player_hit = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_active", game_active, 0);
    chk("rst_freeze", freeze, 1);
    chk("rst_won", end_game_won, 0);
    chk("rst_lost", end_game_lost, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_blink", player_blink, 0);

    start_key = 1; step(2);
    chk("start_latency", game_active, 0);
    step(1);
    chk("start_active", game_active, 1);
    chk("start_freeze", freeze, 0);
    chk("start_lives", lives, 3);
    chk("start_score", score, 0);
    chk("start_flags", {end_game_won, end_game_lost}, 0);
    step(10); start_key = 0; step(1);
    chk("held_key_play", game_active, 1);

    for (int i = 0; i < 15; i++) begin pulse_alien(0); step(1); end
    chk("score15", score, 15);
    chk("play15", game_active, 1);
    pulse_alien(0);
    chk("won_flag", end_game_won, 1);
    chk("won_freeze", freeze, 1);
    chk("won_score", score, 16);
    step(1); pulse_alien(0); player_hit = 1; step(1); player_hit = 0; step(1);
    chk("won_ignore_score", score, 16);
    chk("won_ignore_lives", lives, 3);

    do_reset(); press();
    chk("play2", game_active, 1);
    pulse_player();
    chk("hit1_lives", lives, 2);
    chk("hit1_active", game_active, 0);
    chk("hit1_freeze", freeze, 1);
    pulse_alien(1); step(1);
    chk("hit_ignore_score", score, 0);
    chk("hit_ignore_lives", lives, 2);
    ticks(59);
    chk("hit1_59", game_active, 0);
    ticks(1);
    chk("hit1_60", game_active, 1);
    pulse_player();
    chk("hit2_lives", lives, 1);
    ticks(59);
    chk("hit2_59", game_active, 0);
    ticks(1);
    chk("hit2_60", game_active, 1);
    pulse_player();
    chk("hit3_lost", end_game_lost, 1);
    chk("hit3_lives", lives, 0);
    chk("hit3_active", game_active, 0);

    ticks(100); press();
    chk("lost_early_press", end_game_lost, 1);
    ticks(90);
    start_key = 1; step(2);
    chk("lost_pre", end_game_lost, 1);
    step(1);
    chk("lost_exit", end_game_lost, 0);
    chk("attract_freeze", freeze, 1);
    chk("attract_active", game_active, 0);
    start_key = 0; step(1);

    do_reset(); press();
    aliens_landed = 1; step(1); aliens_landed = 0;
    chk("landed_lost", end_game_lost, 1);
    chk("landed_lives", lives, 0);

    do_reset(); press();
    for (int i = 0; i < 14; i++) begin pulse_alien(0); step(1); end
    pulse_alien(1);
    chk("both_score", score, 15);
    chk("both_lives", lives, 2);
    chk("both_hit", game_active, 0);
    ticks(60);
    chk("both_back", game_active, 1);
    pulse_alien(1);
    chk("last_won", end_game_won, 1);
    chk("last_not_lost", end_game_lost, 0);
    chk("last_lives", lives, 2);
    chk("last_score", score, 16);

    do_reset(); press();
    pulse_player(); ticks(60); pulse_player();
    chk("mid_lives", lives, 1);
    chk("mid_hit", game_active, 0);
`ifdef GAME_PLAYER_BLINK_EN
    chk("blink_entry", player_blink, 1);
    ticks(7);
    chk("blink_7", player_blink, 1);
    ticks(1);
    chk("blink_8", player_blink, 0);
    ticks(8);
    chk("blink_16", player_blink, 1);
`else
    ticks(10);
    chk("blink_off", player_blink, 0);
`endif
    Reset = 1; step(1);
    chk("mid_rst_lives", lives, 3);
    chk("mid_rst_active", game_active, 0);
    chk("mid_rst_freeze", freeze, 1);
    chk("mid_rst_flags", {end_game_won, end_game_lost}, 0);
    chk("mid_rst_blink", player_blink, 0);
    Reset = 0; step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Top-level game sequencer for the space-shooter display path.
- Tracks aliens remaining, player lives and score, and steps through attract, play, hit-pause, won and lost states.
- Drives end_game_won and end_game_lost to color_mapper, and the freeze/enable signals consumed by the player, missile and alien motion blocks.
- Time base is the frame tick derived from frame_clk (VGA VS) inside the Clk domain.

Parameters:
- NUM_ALIENS, 16: aliens per wave; the wave is cleared when the count reaches 0.
- START_LIVES, 3: lives loaded at reset and at game start; legal range 1..3.
- HIT_PAUSE_FRAMES, 60: frames the game freezes after a player hit.
- END_HOLD_FRAMES, 180: minimum frames WON or LOST is held before a restart is accepted.

Ports:
- Clk, input, 1: system clock (50 MHz).
- Reset, input, 1: synchronous, active-high reset.
- frame_clk, input, 1: raw VGA vertical sync, sampled in the Clk domain.
- start_key, input, 1: level, high while the start/fire key is held.
- alien_hit, input, 1: one-Clk pulse per alien destroyed.
- player_hit, input, 1: one-Clk pulse when an alien missile hits the player.
- aliens_landed, input, 1: level, an alien has reached the player row.
- game_active, output, 1: high in PLAY only; enables motion and missile logic.
- freeze, output, 1: high in HIT, WON, LOST and ATTRACT.
- end_game_won, output, 1: to color_mapper.
- end_game_lost, output, 1: to color_mapper.
- score, output, 8: aliens destroyed this game, saturating at 255.
- lives, output, 2: remaining lives.
- player_blink, output, 1: blank-player request while in HIT (see Optional Feature).

Behaviour:
- All outputs are registered.
- Reset, sync and active-high, sets every output and counter in one cycle and overrides any in-flight state:
  - state = ATTRACT, game_active = 0, freeze = 1, both end flags = 0.
  - score = 0, lives = START_LIVES, aliens_left = NUM_ALIENS, frame counter = 0, player_blink = 0.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer, then a rising-edge detect.
  - frame_tick is high for exactly 1 Clk.
  - All frame counting uses frame_tick only.
- start_key is edge-detected the same way as frame_tick (start_press = rising edge). A held key never retriggers.
- States and transitions:
  - ATTRACT: on start_press go to PLAY. Reload score = 0, lives = START_LIVES, aliens_left = NUM_ALIENS.
  - PLAY, evaluated each cycle in this priority:
    - (1) alien_hit: aliens_left -= 1, score += 1 (saturating). If aliens_left was 1, go to WON.
    - (2) aliens_landed: go to LOST, lives = 0.
    - (3) player_hit: lives -= 1. If lives was 1, go to LOST; otherwise go to HIT with frame counter cleared.
  - HIT: frame counter increments on frame_tick. When it reaches HIT_PAUSE_FRAMES-1 and a tick arrives, go to PLAY.
  - WON / LOST: the frame counter counts up to END_HOLD_FRAMES and then holds. Once it has reached END_HOLD_FRAMES, start_press goes to ATTRACT. A start_press arriving earlier is ignored.
- Simultaneous events:
  - alien_hit clearing the last alien in the same cycle as player_hit or aliens_landed: WON wins. The loss is ignored and lives are unchanged.
  - alien_hit and player_hit in the same cycle without clearing the wave: both are applied.
- alien_hit, player_hit and aliens_landed are ignored outside PLAY. Counters must not change in HIT, WON, LOST or ATTRACT.
- Output decode is registered from next-state, so outputs change in the same cycle the state changes:
  - end_game_won = (state == WON); end_game_lost = (state == LOST).
  - game_active = (state == PLAY); freeze = !game_active.
- Widths:
  - aliens_left is $clog2(NUM_ALIENS+1) bits. It never underflows: at 0, alien_hit is a don't-care, because the state is already WON.
  - The frame counter is 8 bits and saturates.

Optional Feature:
- Macro: GAME_PLAYER_BLINK_EN.
- Defined: in HIT, player_blink toggles every 8 frame_ticks, starting at 1 on HIT entry, and is forced to 0 in all other states.
- Undefined: player_blink is tied to 0 and the blink logic is not compiled.
- The port exists in both builds.

Decomposition:
- Package game_pkg holds:
  - enum game_state_t {ATTRACT, PLAY, HIT, WON, LOST}, 3-bit.
  - Default constants NUM_ALIENS_D, START_LIVES_D, HIT_PAUSE_FRAMES_D, END_HOLD_FRAMES_D.
  - Shared with the alien and missile controllers.
- Sub-module edge_pulse: 2-flop synchronizer plus rising-edge detect with a 1-Clk pulse output, on Clk/Reset. It is instantiated twice, for frame_clk and for start_key.

Test Plan:
- Reset, then start_key rising: next cycle state is PLAY, game_active = 1, lives = 3, score = 0, end flags = 0.
- 16 alien_hit pulses: score = 16. end_game_won = 1 on the cycle after the 16th pulse, and freeze = 1.
- 3 player_hit pulses, each separated by 60 frame_ticks:
  - After the 1st and 2nd hits, HIT holds game_active = 0 for exactly 60 ticks.
  - After the 3rd hit, end_game_lost = 1 and lives = 0.
- The 16th alien_hit and player_hit in the same cycle: end_game_won = 1, end_game_lost = 0, lives unchanged.
- In LOST, start_key pressed at tick 100 has no effect. Pressed at tick 190, the next cycle returns to ATTRACT with end_game_lost = 0.
- Reset asserted mid-HIT with lives = 1: next cycle state is ATTRACT, lives = 3, all flags 0. With GAME_PLAYER_BLINK_EN defined, also check that player_blink toggles every 8 ticks during HIT.
